// File: rtl/sd_spi_pkg.sv
// Shared SPI-mode SD definitions: response types and lengths, receiver states, R1 bit positions.
// Used by the command transmitter, the response receiver and the data-token receiver.
package sd_spi_pkg;

    localparam int unsigned RESP_W   = 40;
    localparam int unsigned BITCNT_W = 6;
    localparam int unsigned R1_W     = 8;

    localparam int unsigned LEN_R1  = 8;
    localparam int unsigned LEN_R1B = 8;
    localparam int unsigned LEN_R2  = 16;
    localparam int unsigned LEN_R37 = 40;

    localparam int unsigned R1_IDLE    = 0;
    localparam int unsigned R1_ILLEGAL = 2;

    // In-idle is a status flag, not an error; every other R1 flag counts as an error
    localparam logic [R1_W-2:0] R1_ERR_MASK = (R1_W-1)'(7'h7F & ~(7'(1) << R1_IDLE));

    typedef enum logic [1:0] {
        RESP_R1  = 2'd0,
        RESP_R1B = 2'd1,
        RESP_R2  = 2'd2,
        RESP_R37 = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        SHIFT      = 3'd2,
        BUSY_WAIT  = 3'd3,
        DONE       = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic              timeout;
        logic              r1_err;
        logic [RESP_W-1:0] resp;
    } resp_result_t;

    function automatic logic [BITCNT_W-1:0] resp_len(input resp_type_e t);
        case (t)
            RESP_R1B: return BITCNT_W'(LEN_R1B);
            RESP_R2:  return BITCNT_W'(LEN_R2);
            RESP_R37: return BITCNT_W'(LEN_R37);
            default:  return BITCNT_W'(LEN_R1);
        endcase
    endfunction

    // R1 flag bits [6:0] when a complete response of type t sits right-justified in r
    function automatic logic [R1_W-2:0] r1_flags(input logic [RESP_W-1:0] r, input resp_type_e t);
        case (t)
            RESP_R2:  return r[14:8];
            RESP_R37: return r[38:32];
            default:  return r[6:0];
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_sat_ctr.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag.
module sd_spi_sat_ctr #(
    parameter int unsigned W    = 8,
    parameter int unsigned TERM = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != W'(TERM))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc_c = (cnt_q == W'(TERM));

endmodule

// File: rtl/sd_spi_resp_rx.sv
// Host-side SPI-mode SD response receiver: start-bit hunt, R1/R1b/R2/R3-R7 capture, R1b busy wait.
// Define SDRESP_R1_ABORT_EN to stop R2/R3/R7 reception after an R1 byte flagging an illegal command.
module sd_spi_resp_rx
    import sd_spi_pkg::*;
#(
    parameter int unsigned NCR_MAX  = 8,
    parameter int unsigned BUSY_MAX = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sclk_rise,
    input  logic              miso,
    input  logic              start,
    input  logic [1:0]        resp_type,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              r1_err,
    output logic [RESP_W-1:0] resp
);

    localparam int unsigned NCR_TERM  = NCR_MAX * 8 - 1;
    localparam int unsigned NCR_W     = (NCR_TERM > 1) ? $clog2(NCR_TERM + 1) : 1;
    localparam int unsigned BUSY_W    = 16;
    localparam int unsigned BUSY_TERM = BUSY_MAX - 1;

    rx_state_e           state_q, state_d;
    resp_type_e          type_q, type_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    resp_result_t        res_q, res_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cnt_clr;
    logic                ncr_en;
    logic                bsy_en;
    logic                ncr_tc;
    logic                bsy_tc;
    logic                finish;
    logic [RESP_W-1:0]   shifted;
    logic [BITCNT_W-1:0] bitcnt_inc;

    assign shifted    = {res_q.resp[RESP_W-2:0], miso};
    assign bitcnt_inc = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + BITCNT_W'(1);

    sd_spi_sat_ctr #(.W(NCR_W), .TERM(NCR_TERM)) u_ncr_ctr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (ncr_en),
        .tc_c (ncr_tc)
    );

    sd_spi_sat_ctr #(.W(BUSY_W), .TERM(BUSY_TERM)) u_busy_ctr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (bsy_en),
        .tc_c (bsy_tc)
    );

    // Next-state and next-output logic; only IDLE and DONE act without a strobe
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        bitcnt_d = bitcnt_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        ncr_en   = 1'b0;
        bsy_en   = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    type_d   = resp_type_e'(resp_type);
                    res_d    = '0;
                    bitcnt_d = '0;
                    cnt_clr  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = WAIT_START;
                end
            end
            WAIT_START: begin
                if (sclk_rise) begin
                    if (!miso) begin
                        res_d.resp = shifted;
                        bitcnt_d   = BITCNT_W'(1);
                        state_d    = SHIFT;
                    end else if (ncr_tc) begin
                        res_d.timeout = 1'b1;
                        res_d.resp    = '0;
                        finish        = 1'b1;
                    end else begin
                        ncr_en = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    res_d.resp = shifted;
                    bitcnt_d   = bitcnt_inc;
                    if (bitcnt_inc == resp_len(type_q)) begin
                        res_d.r1_err = |(r1_flags(shifted, type_q) & R1_ERR_MASK);
                        if (type_q == RESP_R1B) begin
                            state_d = BUSY_WAIT;
                        end else begin
                            finish = 1'b1;
                        end
                    end
`ifdef SDRESP_R1_ABORT_EN
                    // v1 cards answer CMD8 with a bare R1; nothing follows it
                    else if ((bitcnt_inc == BITCNT_W'(R1_W)) && shifted[R1_ILLEGAL]) begin
                        res_d.r1_err = 1'b1;
                        finish       = 1'b1;
                    end
`endif
                end
            end
            BUSY_WAIT: begin
                if (sclk_rise) begin
                    if (miso) begin
                        finish = 1'b1;
                    end else if (bsy_tc) begin
                        res_d.timeout = 1'b1;
                        finish        = 1'b1;
                    end else begin
                        bsy_en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (finish) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            type_q   <= RESP_R1;
            bitcnt_q <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            bitcnt_q <= bitcnt_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = res_q.timeout;
    assign r1_err  = res_q.r1_err;
    assign resp    = res_q.resp;

endmodule

// File: tb/tb_sd_spi_resp_rx.sv
// Scoreboard bench for sd_spi_resp_rx: directed and random MISO streams against a bit-stream model.
`timescale 1ns/1ps
module tb_sd_spi_resp_rx;

    localparam int NCR_MAX  = 8;
    localparam int BUSY_MAX = 120;
    localparam int NCR_BITS = NCR_MAX * 8;

    logic        clk       = 1'b0;
    logic        rstn      = 1'b0;
    logic        sclk_rise = 1'b0;
    logic        miso      = 1'b1;
    logic        start     = 1'b0;
    logic [1:0]  resp_type = 2'd0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        r1_err;
    logic [39:0] resp;

    typedef struct {
        int          n;
        logic        to;
        logic        err;
        logic [39:0] r;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    logic stim[$];

    int vectors        = 0;
    int miscompares    = 0;
    int cyc            = 0;
    int strobe_cnt     = 0;
    int last_strobe_cyc = 0;
    int done_cnt       = 0;
    logic done_prev    = 1'b0;

    sd_spi_resp_rx #(.NCR_MAX(NCR_MAX), .BUSY_MAX(BUSY_MAX)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sclk_rise (sclk_rise),
        .miso      (miso),
        .start     (start),
        .resp_type (resp_type),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .r1_err    (r1_err),
        .resp      (resp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_bits(input logic [39:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    task automatic add_ones(input int n);
        for (int i = 0; i < n; i++) stim.push_back(1'b1);
    endtask

    task automatic add_zeros(input int n);
        for (int i = 0; i < n; i++) stim.push_back(1'b0);
    endtask

    // Reference: outcome of a response stream, n = number of strobes up to and including the deciding one
    function automatic exp_t model(input logic bits[$], input int t);
        exp_t        e;
        int          s;
        int          len;
        int          z;
        logic [39:0] r;
        logic [7:0]  r1;
        e.n = 0; e.to = 1'b0; e.err = 1'b0; e.r = '0;
        s = 0;
        while (s < NCR_BITS && bits[s] == 1'b1) s++;
        if (s == NCR_BITS) begin
            e.n  = NCR_BITS;
            e.to = 1'b1;
            return e;
        end
        len = (t == 3) ? 40 : (t == 2) ? 16 : 8;
        r = '0;
        for (int i = 0; i < len; i++) r = {r[38:0], bits[s + i]};
        r1    = 8'(r >> (len - 8));
        e.err = (r1[6:1] != 6'd0);
        e.r   = r;
        e.n   = s + len;
`ifdef SDRESP_R1_ABORT_EN
        if (t >= 2 && r1[2]) begin
            e.r   = 40'(r1);
            e.n   = s + 8;
            e.err = 1'b1;
        end
`endif
        if (t == 1) begin
            z = 0;
            while (z < BUSY_MAX && bits[s + 8 + z] == 1'b0) z++;
            if (z == BUSY_MAX) begin
                e.to = 1'b1;
                e.n  = s + 8 + BUSY_MAX;
            end else begin
                e.n = s + 8 + z + 1;
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done_prev) chk("done_width", 64'(done), 64'(0));
        if (rstn && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(sb.size()), 64'(1));
            end else begin
                me = sb.pop_front();
                chk("resp",          64'(resp),       64'(me.r));
                chk("timeout",       64'(timeout),    64'(me.to));
                chk("r1_err",        64'(r1_err),     64'(me.err));
                chk("busy_at_done",  64'(busy),       64'(0));
                chk("done_strobe",   64'(strobe_cnt), 64'(me.n));
                chk("done_latency",  64'(cyc),        64'(last_strobe_cyc + 1));
            end
            done_cnt++;
        end
        done_prev = done;
    end

    task automatic run_txn(input int t, input bit coinc, input bit poke);
        exp_t e;
        int   dc;
        e = model(stim, t);
        sb.push_back(e);
        start     = 1'b1;
        resp_type = 2'(t);
        if (coinc) begin
            sclk_rise = 1'b1;
            miso      = 1'b0;
        end
        tick();
        start      = 1'b0;
        sclk_rise  = 1'b0;
        miso       = 1'b1;
        strobe_cnt = 0;
        chk("busy_after_start", 64'(busy), 64'(1));
        dc = done_cnt;
        for (int i = 0; i < e.n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                miso = 1'($urandom);
                tick();
            end
            if (poke && i == e.n / 2) begin
                start     = 1'b1;
                resp_type = 2'(~t);
                tick();
                start = 1'b0;
            end
            sclk_rise       = 1'b1;
            miso            = stim[i];
            last_strobe_cyc = cyc;
            strobe_cnt++;
            tick();
            sclk_rise = 1'b0;
        end
        for (int w = 0; w < 4 && done_cnt == dc; w++) tick();
        chk("done_count", 64'(done_cnt - dc), 64'(1));
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            sclk_rise = 1'b1;
            miso      = 1'($urandom);
            tick();
            sclk_rise = 1'b0;
        end
        tick();
        chk("resp_hold",    64'(resp),     64'(e.r));
        chk("timeout_hold", 64'(timeout),  64'(e.to));
        chk("r1_err_hold",  64'(r1_err),   64'(e.err));
        chk("sb_empty",     64'(sb.size()), 64'(0));
    endtask

    task automatic reset_mid_shift();
        start     = 1'b1;
        resp_type = 2'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sclk_rise = 1'b1;
            miso      = (i == 0) ? 1'b0 : 1'b1;
            tick();
            sclk_rise = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy",    64'(busy),    64'(0));
        chk("rst_done",    64'(done),    64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_r1_err",  64'(r1_err),  64'(0));
        chk("rst_resp",    64'(resp),    64'(0));
        tick();
        tick();
        rstn = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        int          t;
        int          idle;
        int          len;
        int          z;
        logic [39:0] v;

        repeat (3) tick();
        chk("reset_busy",    64'(busy),    64'(0));
        chk("reset_done",    64'(done),    64'(0));
        chk("reset_timeout", 64'(timeout), 64'(0));
        chk("reset_r1_err",  64'(r1_err),  64'(0));
        chk("reset_resp",    64'(resp),    64'(0));
        rstn = 1'b1;
        repeat (2) tick();

        // R1 after three idle strobes, with a strobe coincident with start
        stim.delete(); add_ones(3); add_bits(40'h01, 8); add_ones(4);
        run_txn(0, 1'b1, 1'b0);
        // R7 after one idle byte
        stim.delete(); add_ones(8); add_bits(40'h01_0000_01AA, 40); add_ones(4);
        run_txn(3, 1'b0, 1'b0);
        // NCR timeout
        stim.delete(); add_ones(NCR_BITS + 8);
        run_txn(0, 1'b0, 1'b0);
        // Start bit in the last NCR slot
        stim.delete(); add_ones(NCR_BITS - 1); add_bits(40'h00, 8); add_ones(4);
        run_txn(0, 1'b0, 1'b0);
        // R1b with 100 busy strobes
        stim.delete(); add_bits(40'h00, 8); add_zeros(100); add_ones(4);
        run_txn(1, 1'b0, 1'b0);
        // R1b released on the last legal busy strobe
        stim.delete(); add_bits(40'h00, 8); add_zeros(BUSY_MAX - 1); add_ones(4);
        run_txn(1, 1'b0, 1'b0);
        // R1b busy timeout
        stim.delete(); add_bits(40'h00, 8); add_zeros(BUSY_MAX + 10); add_ones(4);
        run_txn(1, 1'b0, 1'b0);
        // Illegal-command R1 in answer to CMD8
        stim.delete(); add_bits(40'h05, 8); add_ones(40);
        run_txn(3, 1'b0, 1'b0);
        // R2 with a stray start while busy
        stim.delete(); add_ones(5); add_bits(40'h00A5, 16); add_ones(4);
        run_txn(2, 1'b0, 1'b1);
        // Reset mid-shift, then a normal response
        reset_mid_shift();
        stim.delete(); add_ones(2); add_bits(40'h7E, 8); add_ones(4);
        run_txn(0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            t = $urandom_range(0, 3);
            stim.delete();
            idle = ($urandom_range(0, 9) == 0) ? NCR_BITS + 2 : $urandom_range(0, NCR_BITS - 1);
            add_ones(idle);
            len = (t == 3) ? 40 : (t == 2) ? 16 : 8;
            v = 40'({$urandom(), $urandom()});
            v[len - 1] = 1'b0;
            add_bits(v, len);
            if (t == 1) begin
                z = ($urandom_range(0, 3) == 0) ? BUSY_MAX + 2 : $urandom_range(0, 40);
                add_zeros(z);
            end
            add_ones(8);
            run_txn(t, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
